// File: rtl/pll_lock_ctrl.sv
// -----------------------------------------------------------------------------
// pll_lock_ctrl
//
// Purpose:
//   Sequences a PLL primitive out of reset and qualifies its lock flag before
//   releasing the logic that runs from the PLL output clock.
//     S_RESET  : hold the PLL in reset for RST_CYCLES clkin cycles
//     S_WAIT   : wait up to TIMEOUT_CYCLES for the synchronized lock flag,
//                otherwise pulse timeout and retry from S_RESET
//     S_STABLE : require LOCK_STABLE consecutive high lock samples
//     S_RUN    : release sys_rst, assert ready; any lock loss or a
//                force_relock request restarts the sequence
//
// Optional feature (compile-time macro PLL_RELOCK_CNT_EN):
//   defined   -> relock_cnt counts S_RUN -> S_RESET transitions, saturating
//                at 255, cleared only by reset
//   undefined -> relock_cnt is tied to 0 and no counter register exists
//
// Ports:
//   clkin         in   27 MHz reference clock, all logic on its rising edge
//   reset         in   synchronous, active-high reset
//   lock          in   raw PLL lock flag, asynchronous to clkin
//   force_relock  in   one-cycle relock request, honoured only in S_RUN
//   pll_reset     out  active-high reset to the PLL primitive
//   sys_rst       out  active-high reset for the PLL-clocked domain
//   ready         out  high only in S_RUN
//   state         out  registered FSM state (S_RESET=0 .. S_RUN=3)
//   timeout       out  one-cycle pulse when a lock wait expires
//   relock_cnt    out  relock event count (see macro above)
// -----------------------------------------------------------------------------
module pll_lock_ctrl #(
  parameter int RST_CYCLES     = 32,    // min 2
  parameter int LOCK_STABLE    = 256,   // min 1
  parameter int TIMEOUT_CYCLES = 65535  // min 1
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       lock,
  input  logic       force_relock,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       ready,
  output logic [1:0] state,
  output logic       timeout,
  output logic [7:0] relock_cnt
);

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_WAIT   = 2'd1,
    S_STABLE = 2'd2,
    S_RUN    = 2'd3
  } state_e;

  // One counter is shared by all states: only one phase is ever being timed,
  // and every state transition clears it, so it never carries across states.
  localparam int MAX_AB  = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int MAX_CYC = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Terminal values: the counter counts 0..N-1, so it can never wrap.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Lock synchronizer (two flops); lock_s_q is the only lock view the FSM uses.
  // ---------------------------------------------------------------------------
  logic lock_meta_q, lock_meta_d;
  logic lock_s_q,    lock_s_d;

  // ---------------------------------------------------------------------------
  // FSM state, counter and registered outputs
  // ---------------------------------------------------------------------------
  state_e           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             timeout_q,   timeout_d;
  logic             pll_reset_q, pll_reset_d;
  logic             sys_rst_q,   sys_rst_d;
  logic             ready_q,     ready_d;

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave a variable unassigned and infer a latch.
    lock_meta_d = lock;
    lock_s_d    = lock_meta_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;

    unique case (state_q)
      S_RESET: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_WAIT: begin
        // A lock seen on the final wait cycle wins over the timeout.
        if (lock_s_q) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = S_RESET;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_STABLE: begin
        // Any low sample restarts qualification; the wait budget restarts too,
        // and a glitch is not a timeout.
        if (!lock_s_q) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_RUN: begin
        // force_relock is only looked at here, which is what makes it a no-op
        // in every other state.
        if (!lock_s_q || force_relock) begin
          state_d = S_RESET;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_RESET;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state and registered, so the PLL and
    // the downstream domain see glitch-free resets that change exactly when
    // the state register does.
    pll_reset_d = (state_d == S_RESET);
    ready_d     = (state_d == S_RUN);
    sys_rst_d   = (state_d != S_RUN);
  end

  always_ff @(posedge clkin) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    // NOTE: reset is synchronous and clears every flop, synchronizer included,
    // so a reset in any state restarts the whole sequence on the next edge.
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= S_RESET;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
    end
  end

  assign state     = state_q;
  assign pll_reset = pll_reset_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign timeout   = timeout_q;

  // ---------------------------------------------------------------------------
  // Relock event counter
  // ---------------------------------------------------------------------------
`ifdef PLL_RELOCK_CNT_EN
  logic [7:0] relock_cnt_q, relock_cnt_d;

  // Lock loss and force_relock in the same cycle are one S_RUN -> S_RESET
  // transition, so keying on the transition counts that case exactly once.
  always_comb begin
    relock_cnt_d = relock_cnt_q;
    if ((state_q == S_RUN) && (state_d == S_RESET) && (relock_cnt_q != 8'hFF)) begin
      relock_cnt_d = relock_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      relock_cnt_q <= 8'd0;
    end else begin
      relock_cnt_q <= relock_cnt_d;
    end
  end

  assign relock_cnt = relock_cnt_q;
`else
  assign relock_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_ctrl
//
// Directed bench for pll_lock_ctrl. The main instance uses RST_CYCLES=32,
// LOCK_STABLE=256 and TIMEOUT_CYCLES=100. A second instance with very short
// phases is used to drive 300 forced relocks cheaply.
// Inputs are driven and outputs sampled on the falling edge of clkin, so
// after n calls of step(1) following a release, exactly n rising edges have
// been processed.
// -----------------------------------------------------------------------------
module tb_pll_lock_ctrl;

`ifdef PLL_RELOCK_CNT_EN
  localparam bit RELOCK_EN = 1'b1;
`else
  localparam bit RELOCK_EN = 1'b0;
`endif

  localparam logic [1:0] S_RESET  = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_STABLE = 2'd2;
  localparam logic [1:0] S_RUN    = 2'd3;

  logic       clkin;
  logic       reset, lock, force_relock;
  logic       pll_reset, sys_rst, ready, timeout;
  logic [1:0] state;
  logic [7:0] relock_cnt;

  logic       reset_f, lock_f, force_f;
  logic       pll_reset_f, sys_rst_f, ready_f, timeout_f;
  logic [1:0] state_f;
  logic [7:0] relock_f;

  int checks = 0;
  int errors = 0;
  int to_seen = 0;

  pll_lock_ctrl #(
    .RST_CYCLES    (32),
    .LOCK_STABLE   (256),
    .TIMEOUT_CYCLES(100)
  ) u_dut (
    .clkin       (clkin),
    .reset       (reset),
    .lock        (lock),
    .force_relock(force_relock),
    .pll_reset   (pll_reset),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .state       (state),
    .timeout     (timeout),
    .relock_cnt  (relock_cnt)
  );

  pll_lock_ctrl #(
    .RST_CYCLES    (2),
    .LOCK_STABLE   (1),
    .TIMEOUT_CYCLES(100)
  ) u_fast (
    .clkin       (clkin),
    .reset       (reset_f),
    .lock        (lock_f),
    .force_relock(force_f),
    .pll_reset   (pll_reset_f),
    .sys_rst     (sys_rst_f),
    .ready       (ready_f),
    .state       (state_f),
    .timeout     (timeout_f),
    .relock_cnt  (relock_f)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic step(input int n);
    repeat (n) @(negedge clkin);
  endtask

  // Steps like step() but also counts timeout pulses seen on the main DUT.
  task automatic step_mon(input int n);
    repeat (n) begin
      @(negedge clkin);
      if (timeout) to_seen++;
    end
  endtask

  // Hold reset for two edges with the given lock level, then release.
  task automatic do_reset(input logic lv);
    reset        = 1'b1;
    force_relock = 1'b0;
    lock         = lv;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; lock = 1'b1; force_relock = 1'b0;
    step(3);
    checks++; if (state !== S_RESET) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, S_RESET); end
    checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL reset_pll_reset: got %b expected 1", pll_reset); end
    checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL reset_sys_rst: got %b expected 1", sys_rst); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    checks++; if (relock_cnt !== 8'd0) begin errors++; $display("FAIL reset_relock_cnt: got %0d expected 0", relock_cnt); end
  endtask

  // Lock tied high: RESET for 32 edges, one WAIT edge, 256 STABLE edges.
  task automatic test_lock_acquire;
    do_reset(1'b1);
    step(31);
    checks++; if (state !== S_RESET || pll_reset !== 1'b1) begin errors++; $display("FAIL acq_last_reset_cycle: state %0d pll_reset %b expected 0/1", state, pll_reset); end
    step(1);
    checks++; if (state !== S_WAIT || pll_reset !== 1'b0) begin errors++; $display("FAIL acq_enter_wait: state %0d pll_reset %b expected 1/0", state, pll_reset); end
    step(1);
    checks++; if (state !== S_STABLE) begin errors++; $display("FAIL acq_enter_stable: got %0d expected %0d", state, S_STABLE); end
    step(255);
    checks++; if (state !== S_STABLE || ready !== 1'b0 || sys_rst !== 1'b1) begin errors++; $display("FAIL acq_last_stable: state %0d ready %b sys_rst %b expected 2/0/1", state, ready, sys_rst); end
    step(1);
    checks++; if (state !== S_RUN || ready !== 1'b1 || sys_rst !== 1'b0) begin errors++; $display("FAIL acq_run: state %0d ready %b sys_rst %b expected 3/1/0", state, ready, sys_rst); end
  endtask

  task automatic test_lock_loss;
    do_reset(1'b1);
    step(289);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL loss_pre_run: ready %b expected 1", ready); end
    lock = 1'b0;
    step(2);
    checks++; if (state !== S_RUN) begin errors++; $display("FAIL loss_sync_latency: got %0d expected %0d", state, S_RUN); end
    step(1);
    checks++; if (state !== S_RESET || ready !== 1'b0 || sys_rst !== 1'b1 || pll_reset !== 1'b1) begin
      errors++; $display("FAIL loss_to_reset: state %0d ready %b sys_rst %b pll_reset %b expected 0/0/1/1", state, ready, sys_rst, pll_reset);
    end
    checks++; if (relock_cnt !== (RELOCK_EN ? 8'd1 : 8'd0)) begin errors++; $display("FAIL loss_relock_cnt: got %0d expected %0d", relock_cnt, RELOCK_EN ? 1 : 0); end
  endtask

  // Lock tied low: WAIT lasts 100 edges, then 32 RESET edges; period 132.
  task automatic test_timeout;
    do_reset(1'b0);
    step(131);
    checks++; if (state !== S_WAIT || timeout !== 1'b0) begin errors++; $display("FAIL to_last_wait: state %0d timeout %b expected 1/0", state, timeout); end
    step(1);
    checks++; if (timeout !== 1'b1 || state !== S_RESET || pll_reset !== 1'b1) begin errors++; $display("FAIL to_first_pulse: timeout %b state %0d pll_reset %b expected 1/0/1", timeout, state, pll_reset); end
    step(1);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b expected 0", timeout); end
    step(130);
    checks++; if (timeout !== 1'b0 || state !== S_WAIT) begin errors++; $display("FAIL to_second_wait: timeout %b state %0d expected 0/1", timeout, state); end
    step(1);
    checks++; if (timeout !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL to_second_pulse: timeout %b ready %b expected 1/0", timeout, ready); end
  endtask

  // One-cycle lock drop at stable count 100 (edge 133 after release).
  task automatic test_glitch;
    do_reset(1'b1);
    to_seen = 0;
    step_mon(133);
    checks++; if (state !== S_STABLE) begin errors++; $display("FAIL gl_pre_stable: got %0d expected %0d", state, S_STABLE); end
    lock = 1'b0;
    step_mon(1);
    lock = 1'b1;
    step_mon(1);
    checks++; if (state !== S_STABLE) begin errors++; $display("FAIL gl_sync_latency: got %0d expected %0d", state, S_STABLE); end
    step_mon(1);
    checks++; if (state !== S_WAIT) begin errors++; $display("FAIL gl_back_to_wait: got %0d expected %0d", state, S_WAIT); end
    step_mon(1);
    checks++; if (state !== S_STABLE) begin errors++; $display("FAIL gl_restable: got %0d expected %0d", state, S_STABLE); end
    step_mon(255);
    checks++; if (state !== S_STABLE || ready !== 1'b0) begin errors++; $display("FAIL gl_full_recount: state %0d ready %b expected 2/0", state, ready); end
    step_mon(1);
    checks++; if (state !== S_RUN || ready !== 1'b1) begin errors++; $display("FAIL gl_run: state %0d ready %b expected 3/1", state, ready); end
    checks++; if (to_seen !== 0) begin errors++; $display("FAIL gl_no_timeout: got %0d pulses expected 0", to_seen); end
  endtask

  task automatic test_force_relock;
    do_reset(1'b1);
    step(289);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL fr_pre_run: ready %b expected 1", ready); end
    force_relock = 1'b1;
    lock         = 1'b0;
    step(1);
    force_relock = 1'b0;
    checks++; if (state !== S_RESET) begin errors++; $display("FAIL fr_to_reset: got %0d expected %0d", state, S_RESET); end
    step(5);
    checks++; if (relock_cnt !== (RELOCK_EN ? 8'd1 : 8'd0)) begin errors++; $display("FAIL fr_counted_once: got %0d expected %0d", relock_cnt, RELOCK_EN ? 1 : 0); end
    step(27);
    checks++; if (state !== S_WAIT) begin errors++; $display("FAIL fr_in_wait: got %0d expected %0d", state, S_WAIT); end
    force_relock = 1'b1;
    step(1);
    force_relock = 1'b0;
    checks++; if (state !== S_WAIT || pll_reset !== 1'b0) begin errors++; $display("FAIL fr_ignored_in_wait: state %0d pll_reset %b expected 1/0", state, pll_reset); end
    checks++; if (relock_cnt !== (RELOCK_EN ? 8'd1 : 8'd0)) begin errors++; $display("FAIL fr_wait_no_count: got %0d expected %0d", relock_cnt, RELOCK_EN ? 1 : 0); end
  endtask

  // Relock count is nonzero here (macro on); reset mid-STABLE must clear all.
  task automatic test_reset_mid_stable;
    int w;
    lock = 1'b1;
    w = 0;
    while (state !== S_STABLE && w < 200) begin step(1); w++; end
    checks++; if (state !== S_STABLE) begin errors++; $display("FAIL rm_reach_stable: got %0d expected %0d after %0d cycles", state, S_STABLE, w); end
    step(50);
    reset = 1'b1;
    step(1);
    checks++; if (state !== S_RESET || pll_reset !== 1'b1 || sys_rst !== 1'b1 || ready !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL rm_outputs: state %0d pll_reset %b sys_rst %b ready %b timeout %b expected 0/1/1/0/0", state, pll_reset, sys_rst, ready, timeout);
    end
    checks++; if (relock_cnt !== 8'd0) begin errors++; $display("FAIL rm_relock_clear: got %0d expected 0", relock_cnt); end
    reset = 1'b0;
    step(31);
    checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL rm_full_restart: pll_reset %b expected 1", pll_reset); end
  endtask

  // 300 forced relocks on the short-phase instance.
  task automatic test_relock_saturate;
    int  w;
    bit  stuck;
    reset_f = 1'b1; lock_f = 1'b1; force_f = 1'b0;
    step(2);
    reset_f = 1'b0;
    stuck = 1'b0;
    for (int i = 1; i <= 300 && !stuck; i++) begin
      w = 0;
      while (ready_f !== 1'b1 && w < 30) begin step(1); w++; end
      if (ready_f !== 1'b1) begin
        checks++; errors++; stuck = 1'b1;
        $display("FAIL sat_wait_ready: ready %b expected 1 within 30 cycles at relock %0d", ready_f, i);
      end else begin
        force_f = 1'b1;
        step(1);
        force_f = 1'b0;
        if (i == 1) begin
          checks++; if (relock_f !== (RELOCK_EN ? 8'd1 : 8'd0)) begin errors++; $display("FAIL sat_first: got %0d expected %0d", relock_f, RELOCK_EN ? 1 : 0); end
          checks++; if (state_f !== S_RESET) begin errors++; $display("FAIL sat_force_to_reset: got %0d expected %0d", state_f, S_RESET); end
        end
        if (i == 254) begin
          checks++; if (relock_f !== (RELOCK_EN ? 8'd254 : 8'd0)) begin errors++; $display("FAIL sat_254: got %0d expected %0d", relock_f, RELOCK_EN ? 254 : 0); end
        end
        if (i == 255) begin
          checks++; if (relock_f !== (RELOCK_EN ? 8'd255 : 8'd0)) begin errors++; $display("FAIL sat_255: got %0d expected %0d", relock_f, RELOCK_EN ? 255 : 0); end
        end
      end
    end
    checks++; if (relock_f !== (RELOCK_EN ? 8'd255 : 8'd0)) begin errors++; $display("FAIL sat_300: got %0d expected %0d", relock_f, RELOCK_EN ? 255 : 0); end
  endtask

  initial begin
    reset = 1'b1; lock = 1'b0; force_relock = 1'b0;
    reset_f = 1'b1; lock_f = 1'b1; force_f = 1'b0;
    test_reset();
    test_lock_acquire();
    test_lock_loss();
    test_timeout();
    test_glitch();
    test_force_relock();
    test_reset_mid_stable();
    test_relock_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
